// File: rtl/i2s_transmitter_if.sv
// -----------------------------------------------------------------------------
// i2s_transmitter_if
// Sample hand-off bus between the voice mixer and the I2S transmitter.
//   i_sample        signed mixed sample (two's complement)
//   i_sample_valid  one-cycle strobe qualifying i_sample
// Modports:
//   master  mixer side, drives the sample bus
//   slave   transmitter side, receives the sample bus
// -----------------------------------------------------------------------------
interface i2s_transmitter_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic signed [SAMPLE_WIDTH-1:0] i_sample;
  logic                           i_sample_valid;

  modport master (
    output i_sample,
    output i_sample_valid
  );

  modport slave (
    input i_sample,
    input i_sample_valid
  );
endinterface

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
// Serialises each mono mixed sample to an external audio DAC. The same word is
// sent in both the left and the right slot. BCLK and LRCLK are derived from
// i_clk by integer division; a holding register decouples the mixer sample
// cadence from the DAC frame cadence.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   s_if           sample bus (slave): i_sample, i_sample_valid
//   i_clear_flags  synchronous clear of o_underrun
//   o_bclk         I2S bit clock
//   o_lrclk        I2S word select (0 = left, 1 = right)
//   o_sdata        I2S serial data, MSB first
//   o_frame_start  one-cycle pulse when a new frame (left slot) begins
//   o_underrun     sticky, a frame started without a fresh sample
//   o_overrun      one-cycle pulse, an unsent sample was overwritten
//
// Build option:
//   I2S_LEFT_JUSTIFIED_EN  defined   -> left-justified data, MSB on LRCLK edge
//                          undefined -> standard Philips I2S (one-bit delay)
// -----------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int BCLK_DIV     = 4,
  parameter int SLOT_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  i2s_transmitter_if.slave        s_if,
  input  logic                    i_clear_flags,
  output logic                    o_bclk,
  output logic                    o_lrclk,
  output logic                    o_sdata,
  output logic                    o_frame_start,
  output logic                    o_underrun,
  output logic                    o_overrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] SAMP_W   = BW'(SAMPLE_WIDTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                         r_state;
  logic [DW-1:0]                  r_div_cnt;
  logic [BW-1:0]                  r_bit_cnt;
  logic signed [SAMPLE_WIDTH-1:0] r_hold;
  logic signed [SAMPLE_WIDTH-1:0] r_shift;
  logic                           r_hold_full;
  logic                           r_bclk;
  logic                           r_lrclk;
  logic                           r_sdata;
  logic                           r_frame_start;
  logic                           r_underrun;
  logic                           r_overrun;

  logic                           w_wrap;
  logic                           w_fall_tick;
  logic                           w_frame_start;
  logic [BW-1:0]                  w_bit_next;
  logic [BW-1:0]                  w_pos;
  logic signed [SAMPLE_WIDTH-1:0] w_word;

  // Serial bit for slot position pos of word.
  function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] word,
                                    input logic [BW-1:0]           pos);
    logic [SAMPLE_WIDTH-1:0] sh;
    sh       = '0;
    slot_bit = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (pos < SAMP_W) begin
      sh       = word >> (SAMP_W - 1'b1 - pos);
      slot_bit = sh[0];
    end
`else
    // Position 0 carries the one-bit delay after the LRCLK edge.
    if ((pos != '0) && (pos <= SAMP_W)) begin
      sh       = word >> (SAMP_W - pos);
      slot_bit = sh[0];
    end
`endif
  endfunction

  assign w_wrap        = (r_state == ST_RUN) && (r_div_cnt == DIV_LAST);
  assign w_fall_tick   = w_wrap && r_bclk;
  assign w_bit_next    = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_frame_start = w_fall_tick && (w_bit_next == '0);
  assign w_pos         = (w_bit_next >= SLOT_W) ? w_bit_next - SLOT_W : w_bit_next;
  // On the frame-start tick the shift register is still being loaded, so the
  // first bit of the frame must come straight from the holding register.
  assign w_word        = w_frame_start ? r_hold : r_shift;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_hold        <= '0;
      r_shift       <= '0;
      r_hold_full   <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;

      // Capture runs in every state. A sample leaving on this very frame-start
      // tick is not lost, so no overrun and hold_full stays set for the new one.
      if (s_if.i_sample_valid) begin
        r_hold      <= s_if.i_sample;
        r_hold_full <= 1'b1;
        r_overrun   <= r_hold_full && !w_frame_start;
      end else if (w_frame_start) begin
        r_hold_full <= 1'b0;
      end

      // Clear first so a same-cycle underrun set below takes priority.
      if (i_clear_flags) begin
        r_underrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_div_cnt <= '0;
          r_bclk    <= 1'b0;
          r_lrclk   <= 1'b0;
          r_sdata   <= 1'b0;
          if (s_if.i_sample_valid) begin
            r_state   <= ST_RUN;
            // Parked on the last bit so the first falling BCLK opens a frame.
            r_bit_cnt <= BIT_LAST;
          end
        end

        ST_RUN: begin
          r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
          if (w_wrap) begin
            r_bclk <= ~r_bclk;
          end
          if (w_fall_tick) begin
            r_bit_cnt <= w_bit_next;
            r_lrclk   <= (w_bit_next >= SLOT_W);
            r_sdata   <= slot_bit(w_word, w_pos);
            if (w_frame_start) begin
              // With no fresh sample the holding register still holds the
              // previous word, so it simply repeats.
              r_shift       <= r_hold;
              r_frame_start <= 1'b1;
              if (!r_hold_full) begin
                r_underrun <= 1'b1;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bclk        = r_bclk;
  assign o_lrclk       = r_lrclk;
  assign o_sdata       = r_sdata;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
// Directed bench for i2s_transmitter (BCLK_DIV=2, SLOT_WIDTH=32, 24-bit words).
// A monitor assembles every 64-bit frame of o_sdata/o_lrclk, one bit per BCLK
// falling edge starting at o_frame_start; the main sequence compares frames
// and flags against hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int SW = 24;

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic [63:0] F_800001 = 64'h80000100_80000100;
  localparam logic [63:0] F_654321 = 64'h65432100_65432100;
  localparam logic [63:0] F_000010 = 64'h00001000_00001000;
  localparam logic [63:0] F_7FFFFF = 64'h7FFFFF00_7FFFFF00;
`else
  localparam logic [63:0] F_800001 = 64'h40000080_40000080;
  localparam logic [63:0] F_654321 = 64'h32A19080_32A19080;
  localparam logic [63:0] F_000010 = 64'h00000800_00000800;
  localparam logic [63:0] F_7FFFFF = 64'h3FFFFF80_3FFFFF80;
`endif
  localparam logic [63:0] F_LR     = 64'h00000000_FFFFFFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic bclk, lrclk, sdata, fs, underrun, overrun;

  i2s_transmitter_if #(.SAMPLE_WIDTH(SW)) u_if ();

  i2s_transmitter #(
    .BCLK_DIV    (2),
    .SLOT_WIDTH  (32),
    .SAMPLE_WIDTH(SW)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .s_if         (u_if),
    .i_clear_flags(clear),
    .o_bclk       (bclk),
    .o_lrclk      (lrclk),
    .o_sdata      (sdata),
    .o_frame_start(fs),
    .o_underrun   (underrun),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic        prev_bclk = 1'b0;
  int          bclk_rises = 0;
  int          ov_cycles  = 0;
  int          fs_cycles  = 0;
  int          nb         = 0;
  int          fr_done    = 0;
  logic [63:0] acc_sd     = '0;
  logic [63:0] acc_lr     = '0;
  logic [63:0] fr_sd [0:15];
  logic [63:0] fr_lr [0:15];

  always @(negedge clk) begin
    prev_bclk <= bclk;
    if (!prev_bclk && bclk) bclk_rises <= bclk_rises + 1;
    if (overrun) ov_cycles <= ov_cycles + 1;
    if (!rst_n) begin
      nb <= 0;
    end else if (fs) begin
      fs_cycles <= fs_cycles + 1;
      acc_sd    <= {63'b0, sdata};
      acc_lr    <= {63'b0, lrclk};
      nb        <= 1;
    end else if (prev_bclk && !bclk && (nb != 0)) begin
      acc_sd <= {acc_sd[62:0], sdata};
      acc_lr <= {acc_lr[62:0], lrclk};
      if (nb == 63) begin
        fr_sd[fr_done[3:0]] <= {acc_sd[62:0], sdata};
        fr_lr[fr_done[3:0]] <= {acc_lr[62:0], lrclk};
        fr_done             <= fr_done + 1;
        nb                  <= 0;
      end else begin
        nb <= nb + 1;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic send(input logic [SW-1:0] s);
    u_if.i_sample       = s;
    u_if.i_sample_valid = 1'b1;
    @(negedge clk);
    u_if.i_sample_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!fs && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!fs) chk("fs_timeout", {63'b0, fs}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- sequence
  int b0, ov0;

  initial begin
    rst_n               = 1'b0;
    clear               = 1'b0;
    u_if.i_sample       = '0;
    u_if.i_sample_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs", {58'b0, bclk, lrclk, sdata, fs, underrun, overrun}, 64'd0);
    rst_n = 1'b1;

    b0 = bclk_rises;
    repeat (20) @(negedge clk);
    chk("idle_no_bclk", 64'(bclk_rises - b0), 64'd0);

    send(24'h800001);
    wait_fs();                                   // frame 0
    chk("uf_first", {63'b0, underrun}, 64'd0);
    ov0 = ov_cycles;

    wait_fs();                                   // frame 1: no new sample
    chk("fr0_sd", fr_sd[0], F_800001);
    chk("fr0_lr", fr_lr[0], F_LR);
    chk("uf_set", {63'b0, underrun}, 64'd1);
    repeat (20) @(negedge clk);
    chk("uf_sticky", {63'b0, underrun}, 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("uf_clear", {63'b0, underrun}, 64'd0);
    send(24'h123456);
    repeat (10) @(negedge clk);
    send(24'h654321);
    repeat (3) @(negedge clk);
    chk("ov_pulse", 64'(ov_cycles - ov0), 64'd1);

    wait_fs();                                   // frame 2, negedge 0
    chk("fr1_sd", fr_sd[1], F_800001);
    chk("fr1_lr", fr_lr[1], F_LR);
    chk("uf_frame2", {63'b0, underrun}, 64'd0);
    repeat (30) @(negedge clk);
    send(24'h000010);                            // returns at negedge 31
    repeat (224) @(negedge clk);                 // negedge 255
    ov0 = ov_cycles;
    send(24'h7FFFFF);                            // sampled on frame-3 start edge
    chk("coinc_fs", {63'b0, fs}, 64'd1);
    repeat (2) @(negedge clk);
    chk("ov_coinc", 64'(ov_cycles - ov0), 64'd0);
    chk("uf_frame3", {63'b0, underrun}, 64'd0);
    chk("fr2_sd", fr_sd[2], F_654321);

    wait_fs();                                   // frame 4
    chk("uf_frame4", {63'b0, underrun}, 64'd0);
    wait_fs();                                   // frame 5: no new sample
    chk("fr3_sd", fr_sd[3], F_000010);
    chk("fr4_sd", fr_sd[4], F_7FFFFF);
    chk("uf_frame5", {63'b0, underrun}, 64'd1);
    @(negedge clk);
    chk("fs_count", 64'(fs_cycles), 64'd6);
    chk("ov_total", 64'(ov_cycles), 64'd1);

    // Asynchronous reset in the middle of a frame, between clock edges.
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {58'b0, bclk, lrclk, sdata, fs, underrun, overrun}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = bclk_rises;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", 64'(bclk_rises - b0), 64'd0);
    send(24'h000001);
    repeat (12) @(negedge clk);
    chk("bclk_restart", {63'b0, (bclk_rises != b0)}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
